// File: rtl/srf_write_arbiter.sv
// -----------------------------------------------------------------------------
// srf_write_arbiter
//
// Arbitrates several write requesters (0 = memory unit, 1 = VXM, 2 = ICU) onto
// the single stream-register-file write port. A winner owns the port for a
// whole burst of req_len beats. Each beat writes one tile. Bursts are never
// preempted. The arbiter always returns to IDLE for one cycle between bursts.
//
// Configuration macro:
//    SRF_ARB_FIXED_PRIO_EN  - when defined, arbitration is fixed priority
//                             (lowest index wins) and there is no pointer.
//                             When undefined, arbitration is round-robin.
//
// Ports:
//    clk               in   clock, all state on the rising edge
//    rst_n             in   asynchronous active-low reset
//    req               in   [NUM_REQ]  write request, held until done/abandon
//    req_stream        in   [NUM_REQ*NUM_STREAM_ID] target stream per requester
//    req_len           in   [NUM_REQ*LW] burst length (tiles) per requester
//    req_data          in   [NUM_REQ*MIN_VEC_LENGTH] current beat data
//    gnt               out  [NUM_REQ] one-hot owner, high every BURST cycle
//    srf_write_enable  out  SRF write strobe
//    srf_write_stream  out  [NUM_STREAM_ID] captured stream of the owner
//    srf_write_tile    out  [TW] beat counter
//    srf_write_data    out  [MIN_VEC_LENGTH] owner's req_data (combinational)
//    burst_done        out  [NUM_REQ] pulse on the owner's last beat
//    err_len           out  [NUM_REQ] pulse, cycle after an invalid-length pick
//    busy              out  high while in BURST
// -----------------------------------------------------------------------------
module srf_write_arbiter #(
   parameter int NUM_REQ             = 3,
   parameter int NUM_STREAM_ID       = 5,
   parameter int MIN_VEC_LENGTH      = 16,
   parameter int NUM_TILES_PER_SLICE = 20,
   localparam int LW = $clog2(NUM_TILES_PER_SLICE + 1),
   localparam int TW = $clog2(NUM_TILES_PER_SLICE)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ*NUM_STREAM_ID-1:0]   req_stream,
   input  logic [NUM_REQ*LW-1:0]              req_len,
   input  logic [NUM_REQ*MIN_VEC_LENGTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]                 gnt,
   output logic                               srf_write_enable,
   output logic [NUM_STREAM_ID-1:0]           srf_write_stream,
   output logic [TW-1:0]                      srf_write_tile,
   output logic [MIN_VEC_LENGTH-1:0]          srf_write_data,
   output logic [NUM_REQ-1:0]                 burst_done,
   output logic [NUM_REQ-1:0]                 err_len,
   output logic                               busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t state, state_next;

   // Unpacked views of the flattened per-requester buses.
   logic [NUM_STREAM_ID-1:0]  stream_arr [NUM_REQ];
   logic [LW-1:0]             len_arr    [NUM_REQ];
   logic [MIN_VEC_LENGTH-1:0] data_arr   [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign stream_arr[gi] = req_stream[gi*NUM_STREAM_ID +: NUM_STREAM_ID];
      assign len_arr[gi]    = req_len[gi*LW +: LW];
      assign data_arr[gi]   = req_data[gi*MIN_VEC_LENGTH +: MIN_VEC_LENGTH];
   end

   // Captured burst context.
   logic [IW-1:0]            owner;
   logic [NUM_STREAM_ID-1:0] cap_stream;
   logic [LW-1:0]            cap_len;
   logic [TW-1:0]            beat;
   logic [NUM_REQ-1:0]       err_pulse;

   // ---------------------------------------------------------------------------
   // Winner selection: isolate the lowest set bit of a candidate vector.
   // ---------------------------------------------------------------------------
   logic               any_req;
   logic [NUM_REQ-1:0] sel_vec;
   logic [NUM_REQ-1:0] win_onehot;
   logic [IW-1:0]      win;

   assign any_req = |req;

`ifdef SRF_ARB_FIXED_PRIO_EN
   assign sel_vec = req;
`else
   logic [IW-1:0]      ptr;
   logic [NUM_REQ-1:0] ptr_mask;
   logic [NUM_REQ-1:0] req_hi;

   // Requests at or above the pointer take precedence; if none, wrap to the
   // lowest request overall.
   assign ptr_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
   assign req_hi   = req & ptr_mask;
   assign sel_vec  = (req_hi != '0) ? req_hi : req;
`endif

   assign win_onehot = sel_vec & (~sel_vec + NUM_REQ'(1));

   // One-hot to index via a prefix OR chain.
   logic [IW-1:0] win_acc [NUM_REQ+1];
   assign win_acc[0] = '0;
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_encode
      assign win_acc[gi+1] = win_acc[gi] | (win_onehot[gi] ? IW'(gi) : '0);
   end
   assign win = win_acc[NUM_REQ];

   logic [LW-1:0] win_len;
   logic          win_len_ok;
   assign win_len    = len_arr[win];
   assign win_len_ok = (win_len != '0) && (win_len <= LW'(NUM_TILES_PER_SLICE));

   // ---------------------------------------------------------------------------
   // Burst progress
   // ---------------------------------------------------------------------------
   logic               owner_req;
   logic               last_beat;
   logic [NUM_REQ-1:0] owner_onehot;

   assign owner_req    = req[owner];
   assign last_beat    = (LW'(beat) == (cap_len - LW'(1)));
   assign owner_onehot = NUM_REQ'(1) << owner;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (any_req && win_len_ok) begin
               state_next = BURST;
            end
         end
         BURST: begin
            // Abandon (request dropped) or final beat both end the burst.
            if (!owner_req || last_beat) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      gnt              = '0;
      srf_write_enable = 1'b0;
      srf_write_stream = '0;
      srf_write_tile   = '0;
      srf_write_data   = '0;
      burst_done       = '0;
      busy             = 1'b0;
      if (state == BURST) begin
         busy = 1'b1;
         gnt  = owner_onehot;
         if (owner_req) begin
            srf_write_enable = 1'b1;
            srf_write_stream = cap_stream;
            srf_write_tile   = beat;
            srf_write_data   = data_arr[owner];
            if (last_beat) begin
               burst_done = owner_onehot;
            end
         end
      end
   end

   assign err_len = err_pulse;

   // ---------------------------------------------------------------------------
   // Capture registers, beat counter, error pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= '0;
         cap_stream <= '0;
         cap_len    <= '0;
         beat       <= '0;
         err_pulse  <= '0;
      end else begin
         err_pulse <= '0;
         if (state == IDLE) begin
            if (any_req) begin
               owner      <= win;
               cap_stream <= stream_arr[win];
               cap_len    <= win_len;
               beat       <= '0;
               if (!win_len_ok) begin
                  err_pulse <= win_onehot;
               end
            end
         end else if (owner_req && !last_beat) begin
            beat <= beat + TW'(1);
         end
      end
   end

`ifndef SRF_ARB_FIXED_PRIO_EN
   // The pointer moves past the winner on every pick, whether it is granted or
   // rejected for length, so an abandoned burst needs no extra advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (state == IDLE && any_req) begin
         ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_srf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_srf_write_arbiter
//
// Scoreboard bench for srf_write_arbiter. The stimulus process advances a
// transaction-level model (owner / beats remaining / round-robin pointer) once
// per cycle and queues the expected port activity. A separate monitor pops
// and compares whenever the DUT shows any activity.
// -----------------------------------------------------------------------------
module tb_srf_write_arbiter;

   localparam int N  = 3;
   localparam int SW = 5;
   localparam int DW = 16;
   localparam int T  = 20;
   localparam int LW = $clog2(T + 1);
   localparam int TW = $clog2(T);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]    req;
   logic [N*SW-1:0] req_stream;
   logic [N*LW-1:0] req_len;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            srf_write_enable;
   logic [SW-1:0]   srf_write_stream;
   logic [TW-1:0]   srf_write_tile;
   logic [DW-1:0]   srf_write_data;
   logic [N-1:0]    burst_done;
   logic [N-1:0]    err_len;
   logic            busy;

   srf_write_arbiter #(
      .NUM_REQ(N), .NUM_STREAM_ID(SW), .MIN_VEC_LENGTH(DW), .NUM_TILES_PER_SLICE(T)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_stream(req_stream),
      .req_len(req_len), .req_data(req_data), .gnt(gnt),
      .srf_write_enable(srf_write_enable), .srf_write_stream(srf_write_stream),
      .srf_write_tile(srf_write_tile), .srf_write_data(srf_write_data),
      .burst_done(burst_done), .err_len(err_len), .busy(busy)
   );

   typedef struct {
      int            cyc;
      logic [N-1:0]  gnt;
      logic          we;
      logic [SW-1:0] stream;
      logic [TW-1:0] tile;
      logic [DW-1:0] data;
      logic [N-1:0]  done;
      logic [N-1:0]  err;
      logic          busy;
   } ev_t;

   ev_t exp_q[$];
   ev_t got;
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   bit  fin   = 1'b0;
   bit  rand_data;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state.
   bit           m_busy;
   int           m_owner, m_stream, m_len, m_beat, m_ptr, m_err;
   logic [N-1:0] last_done, last_err;

   function automatic int pick();
      int w;
      w = 0;
`ifdef SRF_ARB_FIXED_PRIO_EN
      for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
      for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_ptr = (w + 1) % N;
`endif
      return w;
   endfunction

   // Expected behaviour for the current cycle, then advance to the next one.
   task automatic model_step();
      ev_t e;
      int  w, ln;
      e.cyc = cyc; e.gnt = '0; e.we = 1'b0; e.stream = '0; e.tile = '0;
      e.data = '0; e.done = '0; e.err = '0; e.busy = 1'b0;
      last_done = '0;
      last_err  = '0;
      if (!rst_n) begin
         m_busy = 1'b0; m_ptr = 0; m_err = -1;
         return;
      end
      if (m_busy) begin
         e.busy = 1'b1;
         e.gnt[m_owner] = 1'b1;
         if (req[m_owner]) begin
            e.we     = 1'b1;
            e.stream = SW'(m_stream);
            e.tile   = TW'(m_beat);
            e.data   = req_data[m_owner*DW +: DW];
            if (m_beat == m_len - 1) begin
               e.done[m_owner] = 1'b1;
               m_busy = 1'b0;
            end else begin
               m_beat++;
            end
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         if (m_err >= 0) e.err[m_err] = 1'b1;
         m_err = -1;
         if (req != '0) begin
            w  = pick();
            ln = int'(req_len[w*LW +: LW]);
            if (ln == 0 || ln > T) begin
               m_err = w;
            end else begin
               m_busy = 1'b1; m_owner = w; m_len = ln; m_beat = 0;
               m_stream = int'(req_stream[w*SW +: SW]);
            end
         end
      end
      last_done = e.done;
      last_err  = e.err;
      if (e.busy || e.err != '0) exp_q.push_back(e);
   endtask

   task automatic set_req(input int i, input bit r, input int s, input int l);
      req[i] = r;
      req_stream[i*SW +: SW] = SW'(s);
      req_len[i*LW +: LW]    = LW'(l);
   endtask

   task automatic step();
      if (rand_data) for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         total++;
         if ({gnt, srf_write_enable, srf_write_stream, srf_write_tile, srf_write_data,
              burst_done, err_len, busy} != '0) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d gnt=%b we=%b stream=%0d tile=%0d data=%h done=%b err=%b busy=%b want all 0",
                     cyc, gnt, srf_write_enable, srf_write_stream, srf_write_tile,
                     srf_write_data, burst_done, err_len, busy);
         end
      end else if (gnt != '0 || srf_write_enable || burst_done != '0 || err_len != '0 || busy) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d gnt=%b we=%b tile=%0d done=%b err=%b busy=%b want no activity",
                     cyc, gnt, srf_write_enable, srf_write_tile, burst_done, err_len, busy);
         end else begin
            got = exp_q.pop_front();
            if (got.cyc != cyc || got.gnt != gnt || got.we != srf_write_enable ||
                got.stream != srf_write_stream || got.tile != srf_write_tile ||
                got.data != srf_write_data || got.done != burst_done ||
                got.err != err_len || got.busy != busy) begin
               bad++;
               $display("FAIL scoreboard got cyc=%0d gnt=%b we=%b stream=%0d tile=%0d data=%h done=%b err=%b busy=%b want cyc=%0d gnt=%b we=%b stream=%0d tile=%0d data=%h done=%b err=%b busy=%b",
                        cyc, gnt, srf_write_enable, srf_write_stream, srf_write_tile,
                        srf_write_data, burst_done, err_len, busy, got.cyc, got.gnt,
                        got.we, got.stream, got.tile, got.data, got.done, got.err, got.busy);
            end else begin
               $display("txn cyc=%0d gnt=%b we=%b stream=%0d tile=%0d data=%h done=%b err=%b busy=%b",
                        cyc, gnt, srf_write_enable, srf_write_stream, srf_write_tile,
                        srf_write_data, burst_done, err_len, busy);
            end
         end
      end
      if (fin) begin
         total++;
         if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events remaining=%0d want 0 first_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      int r;
      req = '0; req_stream = '0; req_len = '0; req_data = '0;
      rst_n = 1'b0; rand_data = 1'b1;
      m_busy = 1'b0; m_ptr = 0; m_err = -1; m_owner = 0; m_stream = 0; m_len = 0; m_beat = 0;
      last_done = '0; last_err = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single request: stream 7, len 3, data A0/A1/A2.
      rand_data = 1'b0;
      set_req(0, 1'b1, 7, 3);
      req_data[DW-1:0] = 16'h00A0;
      step();
      for (int k = 0; k < 3; k++) begin
         req_data[DW-1:0] = DW'(16'h00A0 + k);
         step();
      end
      req[0] = 1'b0;
      step(); step();
      rand_data = 1'b1;

      // Contention: all three held with len 2.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 2);
      repeat (12) step();
      req = '0;
      step(); step();

      // Bad lengths on requester 1.
      set_req(1, 1'b1, 3, 0);
      repeat (3) step();
      set_req(1, 1'b1, 3, 21);
      repeat (3) step();
      req = '0;
      step(); step();

      // Abandon at beat 5; stream/len changes mid-burst must be ignored.
      set_req(2, 1'b1, 9, 20);
      repeat (3) step();
      set_req(2, 1'b1, 30, 4);
      repeat (3) step();
      req[2] = 1'b0;
      step(); step();

      // Reset at beat 3 of a len-10 burst; request stays pending.
      set_req(0, 1'b1, 12, 10);
      repeat (4) step();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (13) step();
      req = '0;
      step(); step();

      // Randomised traffic.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               r = int'($urandom_range(0, 15));
               set_req(i, 1'b1, int'($urandom_range(0, 31)),
                       (r == 0) ? 0 : (r == 1) ? int'($urandom_range(21, 31))
                                               : int'($urandom_range(1, 20)));
            end else if (req[i] && $urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;
            end else if (req[i] && $urandom_range(0, 7) == 0) begin
               set_req(i, 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(1, 20)));
            end
         end
         step();
         for (int i = 0; i < N; i++) if (last_done[i] || last_err[i]) req[i] = 1'b0;
      end
      req = '0;
      repeat (3) step();
      fin = 1'b1;
   end

endmodule

// File: doc/srf_write_arbiter.md
SRF_WRITE_ARBITER -- requirements
Module: srf_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write requesters; index 0 = memory unit, 1 = VXM, 2 = ICU.
REQ-002 SHALL have parameter NUM_STREAM_ID, default 5, stream-id width (32 SRFs).
REQ-003 SHALL have parameter MIN_VEC_LENGTH, default 16, element width in bits.
REQ-004 SHALL have parameter NUM_TILES_PER_SLICE, default 20, maximum beats per burst; LW = $clog2(NUM_TILES_PER_SLICE+1) and TW = $clog2(NUM_TILES_PER_SLICE).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req, input, NUM_REQ, per-requester write request, held until burst_done or abandon.
REQ-008 SHALL have port req_stream, input, NUM_REQ x NUM_STREAM_ID, target stream id per requester.
REQ-009 SHALL have port req_len, input, NUM_REQ x LW, burst length in tiles per requester.
REQ-010 SHALL have port req_data, input, NUM_REQ x MIN_VEC_LENGTH, current beat data per requester.
REQ-011 SHALL have port gnt, output, NUM_REQ, one-hot; high on every BURST cycle of the owner.
REQ-012 SHALL have port srf_write_enable, srf_write_stream (NUM_STREAM_ID), srf_write_tile (TW) and srf_write_data (MIN_VEC_LENGTH), all outputs driving the SRF write port.
REQ-013 SHALL have port burst_done, output, NUM_REQ, one-cycle pulse on the owner's last beat.
REQ-014 SHALL have port err_len, output, NUM_REQ, one-cycle pulse on an invalid length.
REQ-015 SHALL have port busy, output, 1, high while in BURST.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and BURST.
REQ-017 In IDLE, when any req is high, SHALL select one winner per REQ-024/025 and register its index, stream and len.
REQ-018 If the winner's len is 0 or greater than NUM_TILES_PER_SLICE, SHALL pulse err_len[winner] on the next cycle, perform no writes, stay in IDLE and advance the pointer.
REQ-019 A valid winner SHALL enter BURST on the next cycle; the first write occurs then, so latency from req to first write is 1 cycle.
REQ-020 Each BURST cycle SHALL assert gnt[owner] and srf_write_enable, drive srf_write_stream from the captured stream and srf_write_data = req_data[owner] combinationally, and drive srf_write_tile = beat counter (0..len-1).
REQ-021 On beat len-1, SHALL pulse burst_done[owner] in the same cycle and return to IDLE; one idle cycle always separates bursts.
REQ-022 If req[owner] falls mid-BURST, SHALL suppress the write that cycle, return to IDLE with no burst_done, and advance the pointer (abandon).
REQ-023 Changes to req_stream or req_len during BURST SHALL be ignored; the captured values rule.
REQ-024 Default arbitration SHALL be round-robin: search from the pointer upward with wrap; after each grant or error, pointer = winner+1 mod NUM_REQ.
REQ-025 Requests arriving while in BURST SHALL wait; no preemption.

Reset
REQ-026 On rst_n low, asynchronously: state = IDLE, pointer = 0, beat counter = 0, captured registers = 0.
REQ-027 During reset all outputs SHALL be 0: gnt, srf_write_enable, srf_write_stream, srf_write_tile, srf_write_data, burst_done, err_len and busy.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no burst_done; operation resumes in IDLE after release.

Configuration
REQ-029 With macro SRF_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority (lowest index wins) and the pointer logic SHALL be absent.
REQ-030 Without SRF_ARB_FIXED_PRIO_EN, SHALL use the round-robin arbitration of REQ-024.

Verification
REQ-031 Single request: req[0]=1, stream=7, len=3, data 0xA0/0xA1/0xA2 -> writes to stream 7, tiles 0,1,2 on cycles 1-3 after req; burst_done[0] with tile 2.
REQ-032 Contention: req=3'b111 held, each len=2 -> bursts granted 0,1,2,0 with a 1-cycle gap each (fixed priority under the macro: 0,0,...).
REQ-033 Bad length: req[1]=1, len=0, then len=21 -> err_len[1] pulses, no srf_write_enable, busy stays 0.
REQ-034 Abandon: req[2] len=20, drop req at beat 5 -> exactly 5 writes (tiles 0-4), no burst_done[2], IDLE next cycle.
REQ-035 Reset mid-burst: rst_n low at beat 3 of a len=10 burst -> all outputs 0 immediately; after release, the pending req restarts at tile 0.
